// File: rtl/alu_exec_stage_if.sv
// Handshake bundle between the ALU control decoder, the execute stage and mem/writeback.
// No logic; carries the request channel, the result channel and the flush strobe.
// Backpressure: in_ready/out_ready follow valid/ready semantics; the master side is upstream.
interface alu_exec_stage_if #(
  parameter int DW = 16,
  parameter int RW = 3
);
  // request channel, driven by the upstream decoder
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    alu_control;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [RW-1:0] in_rd;

  // result channel, consumed by mem/writeback
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          out_zero;
  logic          out_ovf;
  logic [RW-1:0] out_rd;

  // upstream producer and downstream consumer viewed as one agent
  modport master (
    output flush, in_valid, alu_control, op_a, op_b, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_ovf, out_rd
  );

  // the execute stage itself
  modport slave (
    input  flush, in_valid, alu_control, op_a, op_b, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_ovf, out_rd
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute stage: 16-bit ALU with zero/overflow flags, registered toward mem/writeback.
// Latency: one cycle from acceptance to out_valid; one op per cycle when out_ready stays high.
// Backpressure: output register plus one skid entry; in_ready is registered and drops only when the skid is full.
module alu_exec_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_stage_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_SHR = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // one held result: value, overflow flag and the destination tag that rides along
  typedef struct packed {
    logic [DW-1:0] result;
    logic          ovf;
    logic [RW-1:0] rd;
  } ent_t;

  ent_t          calc;
  ent_t          or_q;
  ent_t          sk_q;
  logic          or_vld;
  logic          sk_vld;
  logic          rdy_q;
  logic          accept;
  logic          drain;
  logic [DW-1:0] sum;
  logic [DW-1:0] dif;
  logic [3:0]    shamt;
  logic          slt;

  assign sum    = bus.op_a + bus.op_b;
  assign dif    = bus.op_a - bus.op_b;
  assign shamt  = bus.op_b[3:0];
  assign slt    = $signed(bus.op_a) < $signed(bus.op_b);

  assign accept = bus.in_valid & rdy_q;
  assign drain  = or_vld & bus.out_ready;

  // ALU result, overflow and tag for the op being offered this cycle
  always_comb begin
    calc        = '0;
    calc.rd     = bus.in_rd;
    unique case (bus.alu_control)
      OP_ADD: begin
        calc.result = sum;
        calc.ovf    = (bus.op_a[DW-1] == bus.op_b[DW-1]) && (sum[DW-1] != bus.op_a[DW-1]);
      end
      OP_SUB: begin
        calc.result = dif;
        calc.ovf    = (bus.op_a[DW-1] != bus.op_b[DW-1]) && (dif[DW-1] != bus.op_a[DW-1]);
      end
      OP_NOT:  calc.result = ~bus.op_a;
      OP_SHL:  calc.result = bus.op_a << shamt;
      OP_SHR:  calc.result = bus.op_a >> shamt;
      OP_AND:  calc.result = bus.op_a & bus.op_b;
      OP_OR:   calc.result = bus.op_a | bus.op_b;
      OP_SLT:  calc.result = {{(DW-1){1'b0}}, slt};
      default: calc.result = '0;
    endcase
  end

  // Output register and skid entry. The skid only fills when the output register is
  // stalled, and while it is full in_ready is low, so a drain never races an accept
  // into the skid. Flush wins over everything and drops any concurrent accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_vld <= 1'b0;
      sk_vld <= 1'b0;
      rdy_q  <= 1'b1;
      or_q   <= '0;
      sk_q   <= '0;
    end else if (bus.flush) begin
      or_vld <= 1'b0;
      sk_vld <= 1'b0;
      rdy_q  <= 1'b1;
    end else if (sk_vld) begin
      if (drain) begin
        or_q   <= sk_q;
        sk_vld <= 1'b0;
        rdy_q  <= 1'b1;
      end
    end else if (!or_vld || drain) begin
      or_vld <= accept;
      if (accept) begin
        or_q <= calc;
      end
    end else if (accept) begin
      sk_q   <= calc;
      sk_vld <= 1'b1;
      rdy_q  <= 1'b0;
    end
  end

  assign bus.in_ready   = rdy_q;
  assign bus.out_valid  = or_vld;
  assign bus.out_result = or_q.result;
  assign bus.out_ovf    = or_q.ovf;
  assign bus.out_rd     = or_q.rd;
  // zero flag comes from the held result, gated so an empty stage reports 0
  assign bus.out_zero   = or_vld & (or_q.result == '0);

endmodule
